fifo_adc_mc: RTL and testbench



---
 rtl/fifo_adc_mc.sv | 147 ++++++++++++++
 tb/tb_fifo_adc_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_adc_mc.sv
// Frame-based multi-channel ADC sample FIFO: one NUM_CH-wide frame in per write,
// one channel word out per read with channel tag and end-of-frame marker.
module fifo_adc_mc #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 256,
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH * 3 / 4,
    parameter int unsigned AEMPTY_THRESH = 16,
    localparam int unsigned AW  = $clog2(FIFO_DEPTH),
    localparam int unsigned CW  = AW + 1,
    localparam int unsigned CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] adc_data_in,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_valid,
    output logic [CHW-1:0]               ch_id,
    output logic                         frame_last,
    output logic [CW-1:0]                count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned FW = NUM_CH * DATA_WIDTH;

    logic [FW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CHW-1:0]        ch_sel_q, ch_sel_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic [CHW-1:0]        ch_id_q, ch_id_d;
    logic                  frame_last_q, frame_last_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [FW-1:0]         head;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_acc, rd_acc, sel_last, pop;

    // Flags decode the registered count only, so a same-cycle pop never frees a full slot.
    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));

    assign wr_acc   = wr_en && !full && !clear;
    assign rd_acc   = rd_en && !empty && !clear;
    assign sel_last = (ch_sel_q == CHW'(NUM_CH - 1));
    assign pop      = rd_acc && sel_last;

    always_comb begin
        head    = mem_q[rd_ptr_q];
        rd_word = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (ch_sel_q == CHW'(k)) rd_word = head[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ch_sel_d     = ch_sel_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        ch_id_d      = ch_id_q;
        frame_last_d = frame_last_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ch_sel_d    = '0;
            count_d     = '0;
            data_out_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en && full)  overflow_d  = 1'b1;
            if (rd_en && empty) underflow_d = 1'b1;
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) begin
                data_out_d   = rd_word;
                data_valid_d = 1'b1;
                ch_id_d      = ch_sel_q;
                frame_last_d = sel_last;
                if (sel_last) begin
                    ch_sel_d = '0;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end else begin
                    ch_sel_d = ch_sel_q + CHW'(1);
                end
            end
            if (wr_acc && !pop)      count_d = count_q + CW'(1);
            else if (pop && !wr_acc) count_d = count_q - CW'(1);
        end
    end

    // Storage carries no reset; stale slots are never readable because count guards them.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= adc_data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ch_sel_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            ch_id_q      <= '0;
            frame_last_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ch_sel_q     <= ch_sel_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            ch_id_q      <= ch_id_d;
            frame_last_q <= frame_last_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign ch_id      = ch_id_q;
    assign frame_last = frame_last_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_adc_mc.sv
// Directed bench for fifo_adc_mc (2 channels x 16 bits, 256 frames) with a word scoreboard.
module tb_fifo_adc_mc;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned NCH   = 2;
    localparam int unsigned AFT   = 192;
    localparam int unsigned AET   = 16;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   ch;
        bit            last;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clear = 1'b0;
    logic              wr_en = 1'b0;
    logic [NCH*DW-1:0] adc_data_in = '0;
    logic              rd_en = 1'b0;
    logic [DW-1:0]     data_out;
    logic              data_valid;
    logic [0:0]        ch_id;
    logic              frame_last;
    logic [8:0]        count;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;

    exp_t          exp_q[$];
    int unsigned   mcount = 0;
    int unsigned   mch = 0;
    bit            mov = 0, mund = 0, mdv = 0, mlast = 0;
    int unsigned   mchid = 0;
    logic [DW-1:0] mdout = '0;
    int            n_chk = 0;
    int            n_fail = 0;

    fifo_adc_mc #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .NUM_CH       (NCH),
        .AFULL_THRESH (AFT),
        .AEMPTY_THRESH(AET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .wr_en       (wr_en),
        .adc_data_in (adc_data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .ch_id       (ch_id),
        .frame_last  (frame_last),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), mcount);
        chk("full", 32'(full), 32'(mcount == DEPTH));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= AFT));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= AET));
        chk("overflow", 32'(overflow), 32'(mov));
        chk("underflow", 32'(underflow), 32'(mund));
        chk("data_valid", 32'(data_valid), 32'(mdv));
        chk("data_out", 32'(data_out), 32'(mdout));
        if (mdv) begin
            chk("ch_id", 32'(ch_id), mchid);
            chk("frame_last", 32'(frame_last), 32'(mlast));
        end
    endtask

    // One clock edge: advance the reference model with the inputs present at the edge, then check.
    task automatic tick();
        bit   full_m, empty_m, ra, wa, popm;
        exp_t e;
        full_m  = (mcount == DEPTH);
        empty_m = (mcount == 0);
        @(posedge clk);
        #1;
        mdv = 0;
        if (clear) begin
            mcount = 0;
            mch    = 0;
            mov    = 0;
            mund   = 0;
            mdout  = '0;
            exp_q.delete();
        end else begin
            if (wr_en && full_m) mov = 1;
            if (rd_en && empty_m) mund = 1;
            ra   = rd_en && !empty_m;
            wa   = wr_en && !full_m;
            popm = 0;
            if (ra) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e     = exp_q.pop_front();
                    mdout = e.data;
                    mchid = e.ch;
                    mlast = e.last;
                    mdv   = 1;
                end
                if (mch == NCH - 1) begin
                    popm = 1;
                    mch  = 0;
                end else begin
                    mch++;
                end
            end
            if (wa) begin
                for (int k = 0; k < int'(NCH); k++) begin
                    e.data = adc_data_in[k*DW +: DW];
                    e.ch   = k;
                    e.last = (k == int'(NCH) - 1);
                    exp_q.push_back(e);
                end
            end
            if (wa && !popm) mcount++;
            else if (popm && !wa) mcount--;
        end
        check_all();
    endtask

    task automatic wr_frame(input logic [DW-1:0] d1, input logic [DW-1:0] d0);
        wr_en       = 1'b1;
        adc_data_in = {d1, d0};
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd_words(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state, asserted and after release
        #12;
        mcount = 0;
        check_all();
        chk("ch_id_reset", 32'(ch_id), 0);
        chk("frame_last_reset", 32'(frame_last), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();

        // Two frames read word by word
        wr_frame(16'h1111, 16'h0000);
        wr_frame(16'h3333, 16'h2222);
        chk("count_two_frames", 32'(count), 2);
        rd_words(1);
        chk("count_after_w0", 32'(count), 2);
        chk("dout_w0", 32'(data_out), 32'h0000);
        rd_words(1);
        chk("count_after_w1", 32'(count), 1);
        chk("dout_w1", 32'(data_out), 32'h1111);
        rd_words(1);
        chk("dout_w2", 32'(data_out), 32'h2222);
        chk("ch_w2", 32'(ch_id), 0);
        rd_words(1);
        chk("dout_w3", 32'(data_out), 32'h3333);
        chk("last_w3", 32'(frame_last), 1);
        chk("count_after_w3", 32'(count), 0);
        tick();

        // Fill to depth (pointers start at 2, so this wraps), overflow, drain
        for (int i = 0; i < int'(DEPTH); i++) begin
            wr_frame(DW'($urandom), DW'($urandom));
            if (i == int'(AFT) - 2) chk("af_below_thresh", 32'(almost_full), 0);
            if (i == int'(AFT) - 1) chk("af_at_thresh", 32'(almost_full), 1);
        end
        chk("full_at_depth", 32'(full), 1);
        wr_frame(16'hDEAD, 16'hBEEF);
        chk("overflow_257", 32'(overflow), 1);
        chk("count_257", 32'(count), DEPTH);
        rd_words(int'(DEPTH * NCH));
        chk("drained_empty", 32'(empty), 1);
        do_clear();

        // Simultaneous write and pop with count=5
        for (int i = 0; i < 5; i++) wr_frame(DW'(16'h5000 + i), DW'(16'h4000 + i));
        rd_words(int'(NCH) - 1);
        wr_en       = 1'b1;
        adc_data_in = {16'hA5A5, 16'h5A5A};
        rd_en       = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("count_simul_5", 32'(count), 5);

        // Simultaneous write and pop while full: pop taken, write dropped
        for (int i = 0; i < int'(DEPTH) - 5; i++) wr_frame(DW'($urandom), DW'($urandom));
        chk("full_again", 32'(full), 1);
        rd_words(int'(NCH) - 1);
        wr_en       = 1'b1;
        adc_data_in = {16'hFFFF, 16'hEEEE};
        rd_en       = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("count_full_simul", 32'(count), DEPTH - 1);
        chk("overflow_full_simul", 32'(overflow), 1);
        rd_words(int'((DEPTH - 1) * NCH));
        tick();

        // Underflow, then clear wins over a same-cycle write
        rd_words(1);
        chk("underflow_set", 32'(underflow), 1);
        chk("underflow_no_valid", 32'(data_valid), 0);
        clear       = 1'b1;
        wr_en       = 1'b1;
        adc_data_in = {16'h7777, 16'h6666};
        tick();
        clear = 1'b0;
        wr_en = 1'b0;
        chk("clear_count", 32'(count), 0);
        chk("clear_underflow", 32'(underflow), 0);
        tick();
        chk("clear_stored_nothing", 32'(empty), 1);

        // Asynchronous reset after reading ch0 of a frame
        wr_frame(16'h2B2B, 16'h1A1A);
        rd_words(1);
        #2;
        reset = 1'b0;
        #1;
        mcount = 0;
        mch    = 0;
        mov    = 0;
        mund   = 0;
        mdv    = 0;
        mdout  = '0;
        exp_q.delete();
        check_all();
        chk("ch_id_async_reset", 32'(ch_id), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        wr_frame(16'hBEEF, 16'hCAFE);
        rd_words(1);
        chk("post_reset_ch0", 32'(ch_id), 0);
        chk("post_reset_data", 32'(data_out), 32'hCAFE);
        rd_words(1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
